// File: rtl/keyword_nest_pkg.sv
// keyword_nest_pkg: shared constants, keyword ids and helpers for the keyword nesting checker
package keyword_nest_pkg;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B = "b";
    localparam logic [7:0] CH_E = "e";
    localparam logic [7:0] CH_F = "f";
    localparam logic [7:0] CH_J = "j";
    localparam logic KIND_BLOCK = 1'b0;
    localparam logic KIND_FORK = 1'b1;
    typedef enum logic [2:0] {KW_BEGIN, KW_END, KW_FORK, KW_JOIN, KW_NONE} kw_e;
    typedef enum logic [1:0] {M_IDLE, M_ACTIVE, M_DEAD} match_e;
    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    endfunction
    function automatic logic [2:0] kw_len(input kw_e k);
        return k == KW_BEGIN ? 3'd5 : k == KW_END ? 3'd3 : k == KW_NONE ? 3'd0 : 3'd4;
    endfunction
    // Keyword spellings are left-aligned so position p is always byte p from the top.
    function automatic logic [7:0] kw_char(input kw_e k, input logic [2:0] p);
        logic [39:0] s;
        s = k == KW_BEGIN ? "begin" : k == KW_END ? {"end", 16'h0} : k == KW_FORK ? {"fork", 8'h0} : {"join", 8'h0};
        return p > 3'd4 ? 8'h00 : s[39 - 8 * int'(p) -: 8];
    endfunction
    function automatic logic kw_kind(input kw_e k);
        return (k == KW_FORK || k == KW_JOIN) ? KIND_FORK : KIND_BLOCK;
    endfunction
    function automatic logic kw_open(input kw_e k);
        return k == KW_BEGIN || k == KW_FORK;
    endfunction
    function automatic logic kw_close(input kw_e k);
        return k == KW_END || k == KW_JOIN;
    endfunction
endpackage

// File: rtl/keyword_matcher.sv
// keyword_matcher: per-word case-insensitive recogniser for begin/end/fork/join
module keyword_matcher
    import keyword_nest_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in,
    output kw_e        pending_kw,
    output logic       commit
);
    match_e     st_q;
    kw_e        kw_q;
    logic [2:0] pos_q;
    logic [7:0] c;
    kw_e        first_kw;
    assign c = fold(in);
    assign first_kw = c == CH_B ? KW_BEGIN : c == CH_E ? KW_END : c == CH_F ? KW_FORK : c == CH_J ? KW_JOIN : KW_NONE;
    assign commit = in_valid && in == CH_SPACE;
    assign pending_kw = (st_q == M_ACTIVE && pos_q == kw_len(kw_q)) ? kw_q : KW_NONE;
    // Word FSM: a delimiter resets to idle, otherwise advance the prefix or fall dead.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= M_IDLE;
            kw_q  <= KW_NONE;
            pos_q <= '0;
        end else if (in_valid) begin
            if (in == CH_SPACE) begin
                st_q <= M_IDLE;
            end else if (st_q == M_IDLE) begin
                kw_q  <= first_kw;
                pos_q <= 3'd1;
                st_q  <= first_kw == KW_NONE ? M_DEAD : M_ACTIVE;
            end else if (st_q == M_ACTIVE && pos_q < kw_len(kw_q) && c == kw_char(kw_q, pos_q)) begin
                pos_q <= pos_q + 3'd1;
            end else begin
                st_q <= M_DEAD;
            end
        end
    end
endmodule

// File: rtl/keyword_nest_checker.sv
// keyword_nest_checker: bounded kind stack checking begin/end and fork/join nesting
module keyword_nest_checker
    import keyword_nest_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic               error,
    output logic [DEPTH_W-1:0] depth
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    kw_e                pending_kw;
    logic               commit;
    logic [DEPTH-1:0]   stack_q, stack_d;
    logic [DEPTH_W-1:0] sp_q, sp_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   top_idx, push_idx;
    logic               kind;
    keyword_matcher u_matcher (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in         (in),
        .pending_kw (pending_kw),
        .commit     (commit)
    );
    assign top_idx  = IDX_W'(sp_q - 1'b1);
    assign push_idx = IDX_W'(sp_q);
    assign kind     = kw_kind(pending_kw);
    // Committed state with the pending keyword applied: drives the outputs and is what a delimiter commits.
    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        err_d   = err_q;
        if (!err_q && kw_open(pending_kw)) begin
            if (sp_q == DEPTH_W'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                stack_d[push_idx] = kind;
                sp_d = sp_q + 1'b1;
            end
        end else if (!err_q && kw_close(pending_kw)) begin
            if (sp_q == '0 || stack_q[top_idx] != kind) err_d = 1'b1;
            else sp_d = sp_q - 1'b1;
        end
    end
    // Commit the applied state on each accepted delimiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stack_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            stack_q <= stack_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end
    assign depth  = sp_d;
    assign error  = err_d;
    assign result = sp_d == '0 && !err_d;
endmodule

// File: tb/tb_keyword_nest_checker.sv
// tb_keyword_nest_checker: table, directed and random checks against a word-level model
module tb_keyword_nest_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_ch = 8'h00;
    logic       res16, err16, res4, err4;
    logic [4:0] dep16;
    logic [2:0] dep4;
    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned hist[$];

    typedef struct {
        bit    rst;
        string txt;
        int    dep;
        bit    err;
        bit    res;
    } vec_t;
    vec_t tv[$];

    keyword_nest_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
        .result(res16), .error(err16), .depth(dep16)
    );
    keyword_nest_checker #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
        .result(res4), .error(err4), .depth(dep4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input byte unsigned c);
        reset = r;
        in_valid = v;
        in_ch = c;
        @(posedge clk);
        #1;
        if (r) hist.delete();
        else if (v) hist.push_back(c);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(0, 1, s[i]);
    endtask

    function automatic byte unsigned lc(input byte unsigned c);
        return (c >= 8'd65 && c <= 8'd90) ? c + 8'd32 : c;
    endfunction

    function automatic bit word_is(input byte unsigned w[$], input string s);
        if (w.size() != s.len()) return 0;
        foreach (w[i]) if (lc(w[i]) != s[i]) return 0;
        return 1;
    endfunction

    // Replays every accepted character since reset, treating end-of-stream as a final delimiter.
    function automatic void model(input int lim, output int d, output bit e);
        int stk[$];
        byte unsigned w[$];
        int kind;
        e = 0;
        for (int i = 0; i <= hist.size(); i++) begin
            if (i == hist.size() || hist[i] == 8'h20) begin
                kind = (word_is(w, "fork") || word_is(w, "join")) ? 1 : 0;
                if (!e) begin
                    if (word_is(w, "begin") || word_is(w, "fork")) begin
                        if (stk.size() == lim) e = 1;
                        else stk.push_back(kind);
                    end else if (word_is(w, "end") || word_is(w, "join")) begin
                        if (stk.size() == 0 || stk[$] != kind) e = 1;
                        else void'(stk.pop_back());
                    end
                end
                w.delete();
            end else begin
                w.push_back(hist[i]);
            end
        end
        d = stk.size();
    endfunction

    task automatic check_model(input string tag);
        int d;
        bit e;
        model(16, d, e);
        check({tag, " depth16"}, int'(dep16), d);
        check({tag, " error16"}, int'(err16), int'(e));
        check({tag, " result16"}, int'(res16), int'(d == 0 && !e));
        model(4, d, e);
        check({tag, " depth4"}, int'(dep4), d);
        check({tag, " error4"}, int'(err4), int'(e));
        check({tag, " result4"}, int'(res4), int'(d == 0 && !e));
    endtask

    function automatic void add(input bit r, input string t, input int d, input bit e, input bit rs);
        vec_t v;
        v.rst = r; v.txt = t; v.dep = d; v.err = e; v.res = rs;
        tv.push_back(v);
    endfunction

    initial begin
        string toks[10];
        byte unsigned ch;
        toks = '{"begin", "end", "fork", "join", "BEGIN", "FoRk", "JoIn", "EnD", "beginx", "jo"};

        add(1, "", 0, 0, 1);
        add(0, "begin", 1, 0, 0);
        add(0, " ", 1, 0, 0);
        add(0, "end", 0, 0, 1);
        add(1, "BeGiN", 1, 0, 0);
        add(0, " fOrK", 2, 0, 0);
        add(0, " JOIN", 1, 0, 0);
        add(0, " End", 0, 0, 1);
        add(1, "begin join", 1, 1, 0);
        add(0, " end", 1, 1, 0);
        add(1, "begin", 1, 0, 0);
        add(0, "x", 0, 0, 1);
        add(1, "end", 0, 1, 0);
        add(1, "beg", 0, 0, 1);
        add(1, "", 0, 0, 1);
        add(0, "in", 0, 0, 1);
        add(0, " end", 0, 1, 0);
        add(1, "  begin   fork", 2, 0, 0);
        add(0, "  join  end ", 0, 0, 1);
        add(1, "xbegin begi", 0, 0, 1);
        add(1, "fork begin end end", 1, 1, 0);

        foreach (tv[k]) begin
            if (tv[k].rst) step(1, 0, 8'h00);
            feed(tv[k].txt);
            check($sformatf("vec%0d depth", k), int'(dep16), tv[k].dep);
            check($sformatf("vec%0d error", k), int'(err16), int'(tv[k].err));
            check($sformatf("vec%0d result", k), int'(res16), int'(tv[k].res));
        end

        step(1, 0, 8'h00);
        for (int k = 0; k < 4; k++) feed("begin ");
        check("ovf depth4 at 4", int'(dep4), 4);
        check("ovf error4 at 4", int'(err4), 0);
        feed("begin");
        check("ovf error4 fifth", int'(err4), 1);
        check("ovf depth4 fifth", int'(dep4), 4);
        check("ovf result4 fifth", int'(res4), 0);
        check("ovf depth16 fifth", int'(dep16), 5);
        feed(" end");
        check("ovf frozen depth4", int'(dep4), 4);

        step(1, 0, 8'h00);
        step(0, 1, "b");
        step(0, 1, "e");
        step(0, 0, " ");
        step(0, 0, "x");
        check("gap no effect", int'(dep4), 0);
        feed("gin");
        check("gap depth", int'(dep4), 1);
        check("gap result", int'(res4), 0);
        feed(" end");
        check("gap closed", int'(res4), 1);

        step(1, 0, 8'h00);
        feed("begi");
        step(1, 1, "n");
        check("rst prio depth", int'(dep16), 0);
        check("rst prio result", int'(res16), 1);
        feed("egin");
        check("rst prio word", int'(dep16), 0);
        feed(" end");
        check("rst prio underflow", int'(err16), 1);

        for (int r = 0; r < 30; r++) begin
            step(1, 0, 8'h00);
            check_model("rand reset");
            for (int k = 0; k < $urandom_range(4, 14); k++) begin
                string t;
                t = {toks[$urandom_range(0, 9)], ($urandom_range(0, 3) == 0) ? "  " : " "};
                for (int i = 0; i < t.len(); i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ch = 8'($urandom_range(32, 122));
                        step(0, 0, ch);
                        check_model("rand gap");
                    end
                    step(0, 1, t[i]);
                    check_model("rand char");
                end
            end
            feed(toks[$urandom_range(0, 9)]);
            check_model("rand tail");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
